// File: rtl/text_buf_ctrl_if.sv
// Command and character-buffer bus between a host/buffer pair and text_buf_ctrl.
// master = controller side, slave = host + buffer side.
interface text_buf_ctrl_if #(
    parameter int unsigned ASCII_SIZE = 8
);
    localparam int unsigned ROW_W = 5;
    localparam int unsigned COL_W = 7;

    logic                  cmd_valid;
    logic [ASCII_SIZE-1:0] cmd_data;
    logic                  cmd_ready;

    logic                  wr_en;
    logic [ROW_W-1:0]      wr_row;
    logic [COL_W-1:0]      wr_col;
    logic [ASCII_SIZE-1:0] wr_data;

    logic [ROW_W-1:0]      rd_row;
    logic [COL_W-1:0]      rd_col;
    logic [ASCII_SIZE-1:0] rd_data;

    modport master (
        input  cmd_valid, cmd_data, rd_data,
        output cmd_ready, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col
    );

    modport slave (
        output cmd_valid, cmd_data, rd_data,
        input  cmd_ready, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col
    );
endinterface

// File: rtl/text_buf_ctrl.sv
// Text-mode character buffer controller: places glyph codes at the cursor, handles CR/LF/FF.
// Define TEXT_SCROLL_EN to scroll the screen up one row on a row advance past the bottom.
module text_buf_ctrl #(
    parameter int unsigned CHARS_HORZ = 80,
    parameter int unsigned CHARS_VERT = 30,
    parameter int unsigned ASCII_SIZE = 8
) (
    input  logic                clk_25M,
    input  logic                reset_n,
    text_buf_ctrl_if.master     bus,
    output logic [4:0]          cursor_row,
    output logic [6:0]          cursor_col,
    output logic                busy
);
    localparam int unsigned ROW_W = 5;
    localparam int unsigned COL_W = 7;

    localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(CHARS_VERT - 1);
    localparam logic [COL_W-1:0]      LAST_COL = COL_W'(CHARS_HORZ - 1);
    localparam logic [ASCII_SIZE-1:0] CH_SPACE = ASCII_SIZE'(32'h20);
    localparam logic [ASCII_SIZE-1:0] CH_TILDE = ASCII_SIZE'(32'h7E);
    localparam logic [ASCII_SIZE-1:0] CH_LF    = ASCII_SIZE'(32'h0A);
    localparam logic [ASCII_SIZE-1:0] CH_CR    = ASCII_SIZE'(32'h0D);
    localparam logic [ASCII_SIZE-1:0] CH_FF    = ASCII_SIZE'(32'h0C);

`ifdef TEXT_SCROLL_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUT   = 3'd1,
        COPY  = 3'd2,
        BLANK = 3'd3,
        CLEAR = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUT   = 3'd1,
        CLEAR = 3'd4
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      cur_row_q, cur_row_d;
    logic [COL_W-1:0]      cur_col_q, cur_col_d;
    logic                  wr_en_q, wr_en_d;
    logic [ROW_W-1:0]      wr_row_q, wr_row_d;
    logic [COL_W-1:0]      wr_col_q, wr_col_d;
    logic [ASCII_SIZE-1:0] wr_data_q, wr_data_d;
    logic [ROW_W-1:0]      srow_q, srow_d;
    logic [COL_W-1:0]      scol_q, scol_d;
    logic                  tail_q, tail_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  row_adv;

`ifdef TEXT_SCROLL_EN
    logic [ROW_W-1:0]      rd_row_q, rd_row_d;
    logic [COL_W-1:0]      rd_col_q, rd_col_d;
    logic                  pend_q, pend_d;
    logic [ROW_W-1:0]      prow_q, prow_d;
    logic [COL_W-1:0]      pcol_q, pcol_d;
`endif

    // State and datapath registers; reset lands in CLEAR so the screen is blanked first
    always_ff @(posedge clk_25M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            cur_row_q <= '0;
            cur_col_q <= '0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
            srow_q    <= '0;
            scol_q    <= '0;
            tail_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
`ifdef TEXT_SCROLL_EN
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            pend_q    <= 1'b0;
            prow_q    <= '0;
            pcol_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            srow_q    <= srow_d;
            scol_q    <= scol_d;
            tail_q    <= tail_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef TEXT_SCROLL_EN
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            pend_q    <= pend_d;
            prow_q    <= prow_d;
            pcol_q    <= pcol_d;
`endif
        end
    end

    // Next-state logic; tail_q marks the drain cycle that lets the final write land before IDLE
    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        srow_d    = srow_q;
        scol_d    = scol_q;
        tail_d    = tail_q;
        row_adv   = 1'b0;
`ifdef TEXT_SCROLL_EN
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        pend_d    = 1'b0;
        prow_d    = prow_q;
        pcol_d    = pcol_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_data >= CH_SPACE && bus.cmd_data <= CH_TILDE) begin
                        state_d   = PUT;
                        wr_en_d   = 1'b1;
                        wr_row_d  = cur_row_q;
                        wr_col_d  = cur_col_q;
                        wr_data_d = bus.cmd_data;
                    end else if (bus.cmd_data == CH_LF) begin
                        row_adv = 1'b1;
                    end else if (bus.cmd_data == CH_CR) begin
                        cur_col_d = '0;
                    end else if (bus.cmd_data == CH_FF) begin
                        state_d = CLEAR;
                        srow_d  = '0;
                        scol_d  = '0;
                        tail_d  = 1'b0;
                    end
                end
            end

            PUT: begin
                state_d = IDLE;
                if (cur_col_q == LAST_COL) begin
                    row_adv = 1'b1;
                end else begin
                    cur_col_d = cur_col_q + COL_W'(1);
                end
            end

`ifdef TEXT_SCROLL_EN
            // Read (r,c) this cycle, write its data to (r-1,c) once rd_data returns
            COPY: begin
                if (pend_q) begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = prow_q - ROW_W'(1);
                    wr_col_d  = pcol_q;
                    wr_data_d = bus.rd_data;
                end
                if (tail_q) begin
                    tail_d   = 1'b0;
                    state_d  = BLANK;
                    scol_d   = '0;
                    rd_row_d = '0;
                    rd_col_d = '0;
                end else begin
                    pend_d = 1'b1;
                    prow_d = rd_row_q;
                    pcol_d = rd_col_q;
                    if (rd_col_q == LAST_COL) begin
                        rd_col_d = '0;
                        if (rd_row_q == LAST_ROW) begin
                            tail_d = 1'b1;
                        end else begin
                            rd_row_d = rd_row_q + ROW_W'(1);
                        end
                    end else begin
                        rd_col_d = rd_col_q + COL_W'(1);
                    end
                end
            end

            BLANK: begin
                if (tail_q) begin
                    tail_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = LAST_ROW;
                    wr_col_d  = scol_q;
                    wr_data_d = CH_SPACE;
                    if (scol_q == LAST_COL) begin
                        scol_d = '0;
                        tail_d = 1'b1;
                    end else begin
                        scol_d = scol_q + COL_W'(1);
                    end
                end
            end
`endif

            CLEAR: begin
                if (tail_q) begin
                    tail_d    = 1'b0;
                    state_d   = IDLE;
                    cur_row_d = '0;
                    cur_col_d = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = srow_q;
                    wr_col_d  = scol_q;
                    wr_data_d = CH_SPACE;
                    if (scol_q == LAST_COL) begin
                        scol_d = '0;
                        if (srow_q == LAST_ROW) begin
                            srow_d = '0;
                            tail_d = 1'b1;
                        end else begin
                            srow_d = srow_q + ROW_W'(1);
                        end
                    end else begin
                        scol_d = scol_q + COL_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Row advance shared by LF and end-of-row wrap after a PUT
        if (row_adv) begin
            cur_col_d = '0;
            if (cur_row_q == LAST_ROW) begin
`ifdef TEXT_SCROLL_EN
                state_d  = COPY;
                rd_row_d = ROW_W'(1);
                rd_col_d = '0;
                tail_d   = 1'b0;
`else
                cur_row_d = '0;
`endif
            end else begin
                cur_row_d = cur_row_q + ROW_W'(1);
            end
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.cmd_ready = ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_row    = wr_row_q;
    assign bus.wr_col    = wr_col_q;
    assign bus.wr_data   = wr_data_q;
    assign cursor_row    = cur_row_q;
    assign cursor_col    = cur_col_q;
    assign busy          = busy_q;

`ifdef TEXT_SCROLL_EN
    assign bus.rd_row = rd_row_q;
    assign bus.rd_col = rd_col_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^bus.rd_data;
    assign bus.rd_row     = '0;
    assign bus.rd_col     = '0;
`endif
endmodule
